seg_disp_scan: RTL and testbench
================================

SEG_DISP_SCAN -- requirements
Module: seg_disp_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per digit slot (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter DP_HOLD, default 200, scan ticks the new-value decimal point stays lit; legal range 1..1023.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 rst_n  input  1  reset, asynchronous, active-low; the block has one clock.
REQ-005 din  input  8  byte to display (EEPROM read data); may change on any cycle.
REQ-006 mode  input  1  0 = hexadecimal display, 1 = decimal display.
REQ-007 seg  output  8  segments, active-low; bit0..bit6 = a..g, bit7 = dp.
REQ-008 sel  output  3  digit enables, active-low one-hot; bit0 = ones/low nibble, bit2 = hundreds.
REQ-009 upd  output  1  one-cycle pulse when a new value is committed to the display.

Function
REQ-010 din SHALL be registered into din_r every cycle; all decisions use din_r.
REQ-011 Converter FSM states SHALL be IDLE, CONV, COMMIT.
REQ-012 IDLE: if din_r != val_q, load val_q <= din_r, clear the BCD shift register, clear bit_cnt, and go to CONV; otherwise stay in IDLE.
REQ-013 CONV: one double-dabble iteration per cycle (add 3 to each BCD nibble >= 5, then shift left one bit from val_q MSB-first); after 8 iterations (bit_cnt == 7), go to COMMIT.
REQ-014 COMMIT: write hundreds/tens/ones to display registers, pulse upd, load dp_cnt <= DP_HOLD, and return to IDLE.
REQ-015 Latency: with a din change sampled at edge N, upd SHALL be high in the cycle after edge N+10, and the display registers SHALL hold the new value from that edge on.
REQ-016 din changes while in CONV or COMMIT SHALL be ignored; on return to IDLE, din_r is compared again, so the last stable value always wins.
REQ-017 Hex mode: ones slot = val_d[3:0], tens slot = val_d[7:4], hundreds slot blank (val_d = committed value).
REQ-018 Decimal mode: hundreds is blank if 0; tens is blank if hundreds == 0 and tens == 0; ones always shown.
REQ-019 A mode change SHALL take effect in the next displayed slot without reconversion.
REQ-020 Prescaler SHALL count 0..SCAN_DIV-1; at the wrap cycle a scan tick is asserted.
REQ-021 On each tick, digit index SHALL advance 0->1->2->0.
REQ-022 sel/seg SHALL be registered and updated on the tick edge to the new index.
REQ-023 Encoding, bit7 = 1: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E; blank=FF.
REQ-024 A blank slot SHALL still assert its sel bit with seg = FF.
REQ-025 dp_cnt SHALL decrement on each scan tick while nonzero.
REQ-026 While dp_cnt != 0 and index == 0, seg[7] SHALL be 0.
REQ-027 A new commit while dp_cnt != 0 SHALL reload dp_cnt to DP_HOLD.
REQ-028 Simultaneous tick and commit: the reload SHALL win over the decrement.

Reset
REQ-029 rst_n low SHALL immediately force seg = 8'hFF, sel = 3'b111, upd = 0, FSM = IDLE, val_q = 0, din_r = 0, display registers = 0, index = 0, prescaler = 0, dp_cnt = 0.
REQ-030 After release, outputs SHALL stay all-off until the first scan tick, then show "0" on the ones slot, with no upd if din == 0.
REQ-031 Reset asserted mid-CONV SHALL abort the conversion with no upd; the value is reconverted after release if din != 0.

Verification (SCAN_DIV = 4, DP_HOLD = 3)
REQ-032 din 0 -> 8'hD1, mode = 1 -> upd at edge N+10; slots read hundreds "2" (A4), tens "0" (C0), ones "9" (90); seg[7] = 0 on ones for 3 ticks, then 1.
REQ-033 Same value, mode -> 0 -> ones "1" (F9), tens "d" (A1), hundreds FF, with no upd.
REQ-034 din = 8'h07, mode = 1 -> hundreds FF, tens FF, ones F8; din = 8'h64 -> "100" = F9, C0, C0.
REQ-035 din 8'h01 -> 8'h02 -> 8'h03 on consecutive cycles -> exactly two upd pulses; final display value 3.
REQ-036 Reset pulse 4 cycles after a din change -> no upd; outputs FF/111 immediately; after release, a single upd for the held din.
REQ-037 Scan order: ticks every 4 cycles; sel sequence 110 -> 101 -> 011 -> 110, exactly one bit low after the first tick.

Source files
------------

// File: rtl/seg_disp_scan.sv
// ---------------------------------------------------------------------------
// seg_disp_scan
//   Shows an 8-bit value on a three-digit, multiplexed seven-segment display.
//   Each new value is converted to BCD by a double-dabble engine, which does
//   one iteration per clock. The digits are scanned once per SCAN_DIV clocks.
//   A decimal point on the ones digit marks a freshly committed value for
//   DP_HOLD scan ticks.
//
// State table (converter FSM)
//   state  | meaning
//   IDLE   | waiting for din_r to differ from the last accepted value
//   CONV   | double-dabble iterations, one input bit per cycle, MSB first
//   COMMIT | copy BCD/value into display registers, pulse upd, arm dp
//
// Ports
//   clk    in   1  system clock
//   rst_n  in   1  asynchronous active-low reset
//   din    in   8  byte to display
//   mode   in   1  0 = hexadecimal, 1 = decimal
//   seg    out  8  segments, active-low, bit0..6 = a..g, bit7 = dp
//   sel    out  3  digit enables, active-low one-hot (bit0 = ones)
//   upd    out  1  one-cycle pulse when a new value is committed
// ---------------------------------------------------------------------------
module seg_disp_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DP_HOLD  = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       mode,
  output logic [7:0] seg,
  output logic [2:0] sel,
  output logic       upd
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [9:0]    DP_LOAD  = 10'(DP_HOLD);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  state_t      state;
  logic [7:0]  din_r;
  logic [7:0]  val_q;
  logic [7:0]  bin_sh;
  logic [9:0]  bcd;
  logic [2:0]  bit_cnt;

  logic [7:0]  val_d;
  logic [1:0]  dig_h;
  logic [3:0]  dig_t;
  logic [3:0]  dig_o;

  logic [PW-1:0] presc;
  logic          tick;
  logic [1:0]    slot;
  logic [9:0]    dp_cnt;
  logic          commit;

  logic [8:0]  bcd_adj;
  logic [3:0]  nib;
  logic        blank;
  logic [7:0]  seg_next;
  logic [2:0]  sel_next;

  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    return 8'hC0;
      4'h1:    return 8'hF9;
      4'h2:    return 8'hA4;
      4'h3:    return 8'hB0;
      4'h4:    return 8'h99;
      4'h5:    return 8'h92;
      4'h6:    return 8'h82;
      4'h7:    return 8'hF8;
      4'h8:    return 8'h80;
      4'h9:    return 8'h90;
      4'hA:    return 8'h88;
      4'hB:    return 8'h83;
      4'hC:    return 8'hC6;
      4'hD:    return 8'hA1;
      4'hE:    return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  // Input register: every decision is made on din_r, never on raw din.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_r <= 8'h00;
    else        din_r <= din;
  end

  // Hundreds never exceeds 2 for an 8-bit input, so only two bits are kept.
  // Its low bit can never reach 5, so it needs no add-3 step. Its top bit
  // is the one shifted out, so it does not appear here.
  assign bcd_adj = {bcd[8], dd_adj(bcd[7:4]), dd_adj(bcd[3:0])};

  // Converter FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      val_q   <= 8'h00;
      bin_sh  <= 8'h00;
      bcd     <= 10'h000;
      bit_cnt <= 3'd0;
      val_d   <= 8'h00;
      dig_h   <= 2'd0;
      dig_t   <= 4'd0;
      dig_o   <= 4'd0;
      upd     <= 1'b0;
    end else begin
      upd <= 1'b0;
      case (state)
        IDLE: begin
          if (din_r != val_q) begin
            val_q   <= din_r;
            bin_sh  <= din_r;
            bcd     <= 10'h000;
            bit_cnt <= 3'd0;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd     <= {bcd_adj, bin_sh[7]};
          bin_sh  <= {bin_sh[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= COMMIT;
        end
        COMMIT: begin
          dig_h <= bcd[9:8];
          dig_t <= bcd[7:4];
          dig_o <= bcd[3:0];
          val_d <= val_q;
          upd   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign commit = (state == COMMIT);

  // Scan prescaler: counts 0..SCAN_DIV-1, tick on the wrap cycle.
  assign tick = (presc == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else if (tick) presc <= '0;
    else presc <= presc + PW'(1);
  end

  // The decimal-point hold counter is reloaded on commit. The reload wins
  // over a decrement from a tick in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dp_cnt <= 10'd0;
    else if (commit) dp_cnt <= DP_LOAD;
    else if (tick && (dp_cnt != 10'd0)) dp_cnt <= dp_cnt - 10'd1;
  end

  // Slot content. Mode and the display registers are read live, so a mode
  // change shows up on the next slot without a reconversion.
  always_comb begin
    nib   = 4'h0;
    blank = 1'b1;
    if (mode) begin
      case (slot)
        2'd0: begin nib = dig_o;          blank = 1'b0; end
        2'd1: begin nib = dig_t;          blank = (dig_h == 2'd0) && (dig_t == 4'd0); end
        2'd2: begin nib = {2'b00, dig_h}; blank = (dig_h == 2'd0); end
        default: begin nib = 4'h0;        blank = 1'b1; end
      endcase
    end else begin
      case (slot)
        2'd0:    begin nib = val_d[3:0]; blank = 1'b0; end
        2'd1:    begin nib = val_d[7:4]; blank = 1'b0; end
        default: begin nib = 4'h0;       blank = 1'b1; end
      endcase
    end
  end

  always_comb begin
    seg_next = blank ? 8'hFF : glyph(nib);
    if ((slot == 2'd0) && (dp_cnt != 10'd0)) seg_next[7] = 1'b0;
    sel_next = ~(3'b001 << slot);
  end

  // slot names the digit to load on the next tick. It resets to 0, so the
  // first tick after reset lights the ones digit. It then steps 0->1->2->0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= 2'd0;
      seg  <= 8'hFF;
      sel  <= 3'b111;
    end else if (tick) begin
      seg  <= seg_next;
      sel  <= sel_next;
      slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
    end
  end

endmodule

// File: tb/tb_seg_disp_scan.sv
module tb_seg_disp_scan;
  localparam int SCAN_DIV = 4;
  localparam int DP_HOLD  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       mode = 1'b1;
  logic [7:0] seg;
  logic [2:0] sel;
  logic       upd;

  int n_checks = 0;
  int n_fail   = 0;

  seg_disp_scan #(.SCAN_DIV(SCAN_DIV), .DP_HOLD(DP_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode),
    .seg(seg), .sel(sel), .upd(upd)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90; 10: return 8'h88; 11: return 8'h83;
     12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; 15: return 8'h8E;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] slot_seg(input int v, input logic md, input int s, input int dp);
    int d;
    logic [7:0] g;
    if (md) begin
      case (s)
        0:       d = v % 10;
        1:       d = (v >= 10) ? (v / 10) % 10 : 16;
        default: d = (v >= 100) ? v / 100 : 16;
      endcase
    end else begin
      case (s)
        0:       d = v % 16;
        1:       d = v / 16;
        default: d = 16;
      endcase
    end
    g = glyph(d);
    if (s == 0 && dp > 0) g[7] = 1'b0;
    return g;
  endfunction

  int m_din_r, m_val, m_busy, m_disp, m_presc, m_slot, m_dp;
  logic [7:0] m_seg;
  logic [2:0] m_sel;
  logic       m_upd;

  task automatic model_reset();
    m_din_r = 0; m_val = 0; m_busy = 0; m_disp = 0;
    m_presc = 0; m_slot = 0; m_dp = 0;
    m_seg = 8'hFF; m_sel = 3'b111; m_upd = 1'b0;
  endtask

  // A value accepted at one edge is committed nine edges later.
  task automatic model_step();
    bit tick, com;
    tick = (m_presc == SCAN_DIV - 1);
    com = 0;
    if (tick) begin
      m_seg = slot_seg(m_disp, mode, m_slot, m_dp);
      m_sel = 3'b111 ^ 3'(1 << m_slot);
      m_slot = (m_slot + 1) % 3;
    end
    m_upd = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin m_disp = m_val; m_upd = 1'b1; com = 1; end
    end else if (m_din_r != m_val) begin
      m_val = m_din_r;
      m_busy = 9;
    end
    if (com) m_dp = DP_HOLD;
    else if (tick && m_dp > 0) m_dp--;
    m_din_r = int'(din);
    m_presc = tick ? 0 : m_presc + 1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  bit chk_on = 0;
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("model_seg", seg, m_seg);
      check("model_sel", sel, m_sel);
      check("model_upd", upd, m_upd);
    end
  end

  // ---------------- helpers ----------------
  task automatic drive(input logic [7:0] d, input logic m);
    @(negedge clk);
    din = d;
    mode = m;
  endtask

  task automatic count_upd(input int ncyc, output int cnt);
    cnt = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (upd) cnt++;
    end
  endtask

  task automatic capture(output logic [7:0] s0, output logic [7:0] s1, output logic [7:0] s2);
    s0 = 8'h00; s1 = 8'h00; s2 = 8'h00;
    for (int i = 0; i < 3 * SCAN_DIV; i++) begin
      @(negedge clk);
      case (sel)
        3'b110:  s0 = seg;
        3'b101:  s1 = seg;
        3'b011:  s2 = seg;
        default: ;
      endcase
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       m;
    int         n_upd;
    logic [7:0] e_ones;
    logic [7:0] e_tens;
    logic [7:0] e_hund;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int cnt, k, gap;
    logic [7:0] s0, s1, s2;
    logic [2:0] prev, nxt;

    vecs[0]  = '{8'hD1, 1'b0, 0, 8'hF9, 8'hA1, 8'hFF};
    vecs[1]  = '{8'hD1, 1'b1, 0, 8'h90, 8'hC0, 8'hA4};
    vecs[2]  = '{8'h07, 1'b1, 1, 8'hF8, 8'hFF, 8'hFF};
    vecs[3]  = '{8'h64, 1'b1, 1, 8'hC0, 8'hC0, 8'hF9};
    vecs[4]  = '{8'hFF, 1'b1, 1, 8'h92, 8'h92, 8'hA4};
    vecs[5]  = '{8'hFF, 1'b0, 0, 8'h8E, 8'h8E, 8'hFF};
    vecs[6]  = '{8'h0A, 1'b1, 1, 8'hC0, 8'hF9, 8'hFF};
    vecs[7]  = '{8'h00, 1'b1, 1, 8'hC0, 8'hFF, 8'hFF};
    vecs[8]  = '{8'h00, 1'b0, 0, 8'hC0, 8'hC0, 8'hFF};
    vecs[9]  = '{8'h3C, 1'b0, 1, 8'hC6, 8'hB0, 8'hFF};
    vecs[10] = '{8'h5A, 1'b1, 1, 8'hC0, 8'h90, 8'hFF};
    vecs[11] = '{8'hE0, 1'b0, 1, 8'hC0, 8'h86, 8'hFF};

    model_reset();
    repeat (3) @(negedge clk);
    chk_on = 1;

    // Reset state, then dark until the first tick, then "0" on the ones digit
    check("rst_seg", seg, 8'hFF);
    check("rst_sel", sel, 3'b111);
    check("rst_upd", upd, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < SCAN_DIV - 1; i++) begin
      @(negedge clk);
      check("pre_tick_sel", sel, 3'b111);
      check("pre_tick_seg", seg, 8'hFF);
    end
    @(negedge clk);
    check("first_tick_sel", sel, 3'b110);
    check("first_tick_seg", seg, 8'hC0);
    check("first_tick_upd", upd, 1'b0);

    // Latency: upd exactly ten edges after the sampling edge
    drive(8'hD1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("lat_no_upd", upd, 1'b0);
    end
    @(negedge clk);
    check("lat_upd", upd, 1'b1);
    prev = sel;
    k = 0;
    // The decimal point is lit on the ones digit only for the first DP_HOLD ticks
    for (int c = 0; c < 8 * SCAN_DIV && k < 6; c++) begin
      @(negedge clk);
      if (c == 0) check("lat_upd_one_cycle", upd, 1'b0);
      if (sel !== prev) begin
        k++;
        prev = sel;
        check("dp_bit", seg[7], (sel == 3'b110 && k <= DP_HOLD) ? 1'b0 : 1'b1);
      end
    end
    check("dp_ticks_seen", k, 6);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].d, vecs[i].m);
      count_upd(30, cnt);
      check("vec_upd_count", cnt, vecs[i].n_upd);
      capture(s0, s1, s2);
      check("vec_ones", s0, vecs[i].e_ones);
      check("vec_tens", s1, vecs[i].e_tens);
      check("vec_hund", s2, vecs[i].e_hund);
    end

    // Back-to-back changes: the first is taken, the last stable value wins
    drive(8'h01, 1'b1);
    drive(8'h02, 1'b1);
    drive(8'h03, 1'b1);
    count_upd(40, cnt);
    check("burst_upd_count", cnt, 2);
    capture(s0, s1, s2);
    check("burst_ones", s0, 8'hB0);
    check("burst_tens", s1, 8'hFF);
    check("burst_hund", s2, 8'hFF);

    // Reset in the middle of a conversion
    drive(8'h55, 1'b1);
    count_upd(4, cnt);
    check("midconv_no_upd_before", cnt, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midconv_rst_seg", seg, 8'hFF);
    check("midconv_rst_sel", sel, 3'b111);
    check("midconv_rst_upd", upd, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_upd(30, cnt);
    check("midconv_upd_after", cnt, 1);
    capture(s0, s1, s2);
    check("midconv_ones", s0, 8'h92);
    check("midconv_tens", s1, 8'h80);
    check("midconv_hund", s2, 8'hFF);

    // Scan order and tick spacing
    prev = sel;
    k = 0;
    gap = 0;
    for (int c = 0; c < 7 * SCAN_DIV && k < 6; c++) begin
      @(negedge clk);
      gap++;
      if (sel !== prev) begin
        nxt = {prev[1:0], prev[2]};
        check("scan_order", sel, nxt);
        if (k > 0) check("scan_spacing", gap, SCAN_DIV);
        k++;
        gap = 0;
        prev = sel;
      end
    end
    check("scan_ticks_seen", k, 6);

    // Randomized traffic against the reference model
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) >= 3) din = 8'($urandom_range(0, 255));
      mode = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 14)) @(negedge clk);
      if (i == 40) begin
        #2 rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_n = 1'b1;
      end
    end
    repeat (40) @(negedge clk);
    chk_on = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
